// File: rtl/sys_bus_ctrl.sv
// -----------------------------------------------------------------------------
// sys_bus_ctrl
//
// Single-master system-bus controller. It decodes the core's request by address
// slot (core_addr_i[31:24]), raises a registered one-hot request towards the
// selected device and stalls the core until that device reports ready. Read
// data is registered back to the core. Unmapped slots and devices that never
// answer within TIMEOUT access cycles are ended with an error response that
// returns ERR_DATA.
//
// Ports
//   clk_i         system clock, rising edge
//   rst_i         synchronous active-high reset
//   core_req_i    core request, held high while stalled
//   core_we_i     core write enable (1 = write)
//   core_addr_i   core byte address; [31:24] selects the slot
//   core_be_i     core byte enables
//   core_wd_i     core write data
//   core_rd_o     registered read data, valid in the DONE cycle
//   core_stall_o  stall to the core (combinational)
//   bus_err_o     one-cycle error pulse in the DONE cycle of a failed access
//   dev_req_o     registered one-hot device request
//   dev_we_o      latched write enable
//   dev_be_o      latched byte enables
//   dev_addr_o    latched slot offset {8'h00, addr[23:0]}
//   dev_wd_o      latched write data
//   dev_rd_i      device read data, slot k at [32k+31:32k]
//   dev_ready_i   per-device ready
// -----------------------------------------------------------------------------
module sys_bus_ctrl #(
   parameter int          N_DEV    = 8,
   parameter int          TIMEOUT  = 15,
   parameter logic [31:0] ERR_DATA = 32'hDEAD_BEEF
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  core_req_i,
   input  logic                  core_we_i,
   input  logic [31:0]           core_addr_i,
   input  logic [3:0]            core_be_i,
   input  logic [31:0]           core_wd_i,
   output logic [31:0]           core_rd_o,
   output logic                  core_stall_o,
   output logic                  bus_err_o,
   output logic [N_DEV-1:0]      dev_req_o,
   output logic                  dev_we_o,
   output logic [3:0]            dev_be_o,
   output logic [31:0]           dev_addr_o,
   output logic [31:0]           dev_wd_o,
   input  logic [N_DEV*32-1:0]   dev_rd_i,
   input  logic [N_DEV-1:0]      dev_ready_i
);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_DONE   = 2'd2
   } state_t;

   localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);

   state_t            state_q, state_d;
   logic [7:0]        cnt_q, cnt_d;
   logic              err_q, err_d;
   logic [N_DEV-1:0]  req_q, req_d;
   logic              we_q, we_d;
   logic [3:0]        be_q, be_d;
   logic [31:0]       addr_q, addr_d;
   logic [31:0]       wd_q, wd_d;
   logic [31:0]       rd_q, rd_d;

   logic [7:0]        slot;
   logic              mapped;
   logic [N_DEV-1:0]  decode;
   logic              ready_sel;
   logic [31:0]       rd_sel;

   // Slot decode of the incoming request. The compare is done one bit wider so
   // that N_DEV = 256 still maps every slot.
   always_comb begin
      slot   = core_addr_i[31:24];
      mapped = ({1'b0, slot} < 9'(N_DEV));
      decode = '0;
      for (int k = 0; k < N_DEV; k++) begin
         decode[k] = (slot == 8'(k));
      end
   end

   // The registered one-hot request doubles as the slot selector, so ready and
   // read data of non-selected devices are masked off without a slot index.
   always_comb begin
      ready_sel = |(dev_ready_i & req_q);
      rd_sel    = '0;
      for (int k = 0; k < N_DEV; k++) begin
         if (req_q[k]) begin
            rd_sel = rd_sel | dev_rd_i[k*32 +: 32];
         end
      end
   end

   // Next-state and next-register logic
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      err_d   = err_q;
      req_d   = req_q;
      we_d    = we_q;
      be_d    = be_q;
      addr_d  = addr_q;
      wd_d    = wd_q;
      rd_d    = rd_q;

      unique case (state_q)
         ST_IDLE: begin
            if (core_req_i) begin
               if (mapped) begin
                  we_d    = core_we_i;
                  be_d    = core_be_i;
                  addr_d  = {8'h00, core_addr_i[23:0]};
                  wd_d    = core_wd_i;
                  req_d   = decode;
                  cnt_d   = 8'd0;
                  err_d   = 1'b0;
                  state_d = ST_ACCESS;
               end else begin
                  err_d   = 1'b1;
                  rd_d    = ERR_DATA;
                  state_d = ST_DONE;
               end
            end
         end

         ST_ACCESS: begin
            // Ready wins over timeout, including on the last allowed cycle.
            if (ready_sel) begin
               if (!we_q) begin
                  rd_d = rd_sel;
               end
               req_d   = '0;
               err_d   = 1'b0;
               state_d = ST_DONE;
            end else begin
               cnt_d = cnt_q + 8'd1;
               if (cnt_d == TIMEOUT_C) begin
                  req_d   = '0;
                  err_d   = 1'b1;
                  rd_d    = ERR_DATA;
                  state_d = ST_DONE;
               end
            end
         end

         ST_DONE: begin
            state_d = ST_IDLE;
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and output registers
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= ST_IDLE;
         cnt_q   <= 8'd0;
         err_q   <= 1'b0;
         req_q   <= '0;
         we_q    <= 1'b0;
         be_q    <= 4'd0;
         addr_q  <= 32'd0;
         wd_q    <= 32'd0;
         rd_q    <= 32'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         err_q   <= err_d;
         req_q   <= req_d;
         we_q    <= we_d;
         be_q    <= be_d;
         addr_q  <= addr_d;
         wd_q    <= wd_d;
         rd_q    <= rd_d;
      end
   end

   // The core is released only in DONE; reset releases it immediately.
   assign core_stall_o = core_req_i & (state_q != ST_DONE) & ~rst_i;
   assign bus_err_o    = (state_q == ST_DONE) & err_q;

   assign core_rd_o  = rd_q;
   assign dev_req_o  = req_q;
   assign dev_we_o   = we_q;
   assign dev_be_o   = be_q;
   assign dev_addr_o = addr_q;
   assign dev_wd_o   = wd_q;

endmodule

// File: tb/tb_sys_bus_ctrl.sv
// -----------------------------------------------------------------------------
// tb_sys_bus_ctrl
//
// Bench for sys_bus_ctrl. A transaction-level model predicts, cycle by cycle,
// what the outputs must be from the controller's timing rules (cycle 0 request,
// n access cycles, one DONE cycle). One compare process checks every cycle;
// directed transactions add literal expectations.
// -----------------------------------------------------------------------------
module tb_sys_bus_ctrl;

   localparam int          N   = 8;
   localparam int          TO  = 15;
   localparam logic [31:0] ERR = 32'hDEAD_BEEF;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              core_req = 1'b0;
   logic              core_we = 1'b0;
   logic [31:0]       core_addr = '0;
   logic [3:0]        core_be = '0;
   logic [31:0]       core_wd = '0;
   logic [31:0]       core_rd;
   logic              core_stall;
   logic              bus_err;
   logic [N-1:0]      dev_req;
   logic              dev_we;
   logic [3:0]        dev_be;
   logic [31:0]       dev_addr;
   logic [31:0]       dev_wd;
   logic [N*32-1:0]   dev_rd = '0;
   logic [N-1:0]      dev_ready = '0;

   always #5 clk = ~clk;

   sys_bus_ctrl #(.N_DEV(N), .TIMEOUT(TO), .ERR_DATA(ERR)) dut (
      .clk_i        (clk),
      .rst_i        (rst),
      .core_req_i   (core_req),
      .core_we_i    (core_we),
      .core_addr_i  (core_addr),
      .core_be_i    (core_be),
      .core_wd_i    (core_wd),
      .core_rd_o    (core_rd),
      .core_stall_o (core_stall),
      .bus_err_o    (bus_err),
      .dev_req_o    (dev_req),
      .dev_we_o     (dev_we),
      .dev_be_o     (dev_be),
      .dev_addr_o   (dev_addr),
      .dev_wd_o     (dev_wd),
      .dev_rd_i     (dev_rd),
      .dev_ready_i  (dev_ready)
   );

   int total = 0;
   int bad   = 0;
   bit chk_en = 1'b0;

   // model state: expected outputs for the current cycle
   logic [N-1:0] exp_req   = '0;
   logic         exp_stall = 1'b0;
   logic         exp_err   = 1'b0;
   logic         m_we      = 1'b0;
   logic [3:0]   m_be      = '0;
   logic [31:0]  m_addr    = '0;
   logic [31:0]  m_wd      = '0;
   logic [31:0]  m_rd      = '0;

   // observations over the latest transaction
   int           req_cycles   = 0;
   int           stall_cycles = 0;
   int           err_cycles   = 0;
   logic [N-1:0] req_seen     = '0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s actual=%h required=%h (t=%0t)", nm, act, req, $time);
      end
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         chk("dev_req",    32'(dev_req),    32'(exp_req));
         chk("core_stall", 32'(core_stall), 32'(exp_stall));
         chk("bus_err",    32'(bus_err),    32'(exp_err));
         chk("dev_we",     32'(dev_we),     32'(m_we));
         chk("dev_be",     32'(dev_be),     32'(m_be));
         chk("dev_addr",   dev_addr,        m_addr);
         chk("dev_wd",     dev_wd,          m_wd);
         chk("core_rd",    core_rd,         m_rd);
         if (dev_req != '0) req_cycles++;
         if (core_stall)    stall_cycles++;
         if (bus_err)       err_cycles++;
         req_seen = req_seen | dev_req;
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic noise(input int sel);
      for (int k = 0; k < N; k++) dev_rd[k*32 +: 32] = $urandom;
      dev_ready = N'($urandom);
      if (sel >= 0) dev_ready[sel] = 1'b0;
   endtask

   task automatic rand_core();
      core_req  = 1'($urandom);
      core_we   = 1'($urandom);
      core_addr = $urandom;
      core_be   = 4'($urandom);
      core_wd   = $urandom;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         step();
         rand_core();
         core_req  = 1'b0;
         noise(-1);
         exp_req   = '0;
         exp_stall = 1'b0;
         exp_err   = 1'b0;
      end
   endtask

   // One transaction. rdy_at: ACCESS cycle on which the slot answers (0 or
   // beyond TO = never). rst_at: ACCESS cycle with reset (0 = none).
   task automatic do_txn(input logic [31:0] addr, input logic we, input logic [3:0] be,
                         input logic [31:0] wd, input int rdy_at, input int rst_at,
                         input logic [31:0] rdata, input bit core_noise);
      int slot;
      int n;
      bit ok;
      slot = int'(addr[31:24]);
      req_cycles   = 0;
      stall_cycles = 0;
      err_cycles   = 0;
      req_seen     = '0;

      // cycle 0: request presented in IDLE
      step();
      core_req  = 1'b1;
      core_we   = we;
      core_addr = addr;
      core_be   = be;
      core_wd   = wd;
      noise(-1);
      exp_req   = '0;
      exp_stall = 1'b1;
      exp_err   = 1'b0;

      if (slot >= N) begin
         step();
         rand_core();
         noise(-1);
         m_rd      = ERR;
         exp_req   = '0;
         exp_stall = 1'b0;
         exp_err   = 1'b1;
         return;
      end

      ok = (rdy_at >= 1) && (rdy_at <= TO);
      n  = ok ? rdy_at : TO;
      for (int k = 1; k <= n; k++) begin
         step();
         if (k == 1) begin
            m_we   = we;
            m_be   = be;
            m_addr = {8'h00, addr[23:0]};
            m_wd   = wd;
         end
         if (core_noise) rand_core();
         noise(slot);
         if (k == rdy_at) begin
            dev_ready[slot]         = 1'b1;
            dev_rd[slot*32 +: 32]   = rdata;
         end
         exp_req   = N'(1) << slot;
         exp_stall = core_req;
         exp_err   = 1'b0;
         if (k == rst_at) begin
            rst       = 1'b1;
            exp_stall = 1'b0;
            step();
            rst       = 1'b0;
            core_req  = 1'b0;
            noise(-1);
            m_we = 1'b0; m_be = '0; m_addr = '0; m_wd = '0; m_rd = '0;
            exp_req   = '0;
            exp_stall = 1'b0;
            exp_err   = 1'b0;
            return;
         end
      end

      // DONE cycle
      step();
      rand_core();
      noise(-1);
      if (!ok)      m_rd = ERR;
      else if (!we) m_rd = rdata;
      exp_req   = '0;
      exp_stall = 1'b0;
      exp_err   = !ok;
   endtask

   task automatic settle();
      @(negedge clk);
      #1;
   endtask

   initial begin
      int r;
      int slot;
      core_req = 1'b1;   // stall must stay low while reset is asserted
      step();
      step();
      chk_en = 1'b1;
      settle();
      chk("reset_stall", 32'(core_stall), 32'd0);
      chk("reset_req",   32'(dev_req),    32'd0);
      chk("reset_rd",    core_rd,         32'd0);
      step();
      rst      = 1'b0;
      core_req = 1'b0;

      // read, slot 0, immediate ready
      do_txn(32'h0000_0004, 1'b0, 4'hF, 32'h0, 1, 0, 32'h1234_5678, 1'b0);
      settle();
      chk("rd0_req_cycles",   32'(req_cycles),   32'd1);
      chk("rd0_stall_cycles", 32'(stall_cycles), 32'd2);
      chk("rd0_req_seen",     32'(req_seen),     32'h01);
      chk("rd0_addr",         dev_addr,          32'h0000_0004);
      chk("rd0_data",         core_rd,           32'h1234_5678);
      chk("rd0_err_cycles",   32'(err_cycles),   32'd0);

      // write, slot 3, immediate ready
      do_txn(32'h0300_0010, 1'b1, 4'b0001, 32'h0000_00A5, 1, 0, 32'hFFFF_FFFF, 1'b0);
      settle();
      chk("wr3_req_seen", 32'(req_seen), 32'h08);
      chk("wr3_we",       32'(dev_we),   32'd1);
      chk("wr3_be",       32'(dev_be),   32'h1);
      chk("wr3_addr",     dev_addr,      32'h0000_0010);
      chk("wr3_wd",       dev_wd,        32'h0000_00A5);
      chk("wr3_rd_kept",  core_rd,       32'h1234_5678);

      // read, slot 7, ready on ACCESS cycle 4 (other slots' ready is noise)
      do_txn(32'h0700_0020, 1'b0, 4'hF, 32'h0, 4, 0, 32'hCAFE_0007, 1'b0);
      settle();
      chk("rd7_req_seen",     32'(req_seen),     32'h80);
      chk("rd7_req_cycles",   32'(req_cycles),   32'd4);
      chk("rd7_stall_cycles", 32'(stall_cycles), 32'd5);
      chk("rd7_data",         core_rd,           32'hCAFE_0007);

      // unmapped slot 9
      do_txn(32'h0900_0000, 1'b0, 4'hF, 32'h0, 1, 0, 32'h0, 1'b0);
      settle();
      chk("unm_req_cycles",   32'(req_cycles),   32'd0);
      chk("unm_stall_cycles", 32'(stall_cycles), 32'd1);
      chk("unm_err_cycles",   32'(err_cycles),   32'd1);
      chk("unm_data",         core_rd,           32'hDEAD_BEEF);

      // timeout on slot 3, then ready exactly on the last allowed cycle
      do_txn(32'h0300_0000, 1'b0, 4'hF, 32'h0, 0, 0, 32'h0, 1'b0);
      settle();
      chk("to_req_cycles",  32'(req_cycles), 32'd15);
      chk("to_err_cycles",  32'(err_cycles), 32'd1);
      chk("to_data",        core_rd,         32'hDEAD_BEEF);
      do_txn(32'h0300_0000, 1'b0, 4'hF, 32'h0, 15, 0, 32'h55AA_0315, 1'b0);
      settle();
      chk("late_req_cycles", 32'(req_cycles), 32'd15);
      chk("late_err_cycles", 32'(err_cycles), 32'd0);
      chk("late_data",       core_rd,         32'h55AA_0315);

      // reset on ACCESS cycle 2 of a slot 0 read
      do_txn(32'h0000_0008, 1'b0, 4'hF, 32'h0, 5, 2, 32'h7777_7777, 1'b0);
      settle();
      chk("rst_req",        32'(dev_req),    32'd0);
      chk("rst_rd",         core_rd,         32'd0);
      chk("rst_stall",      32'(core_stall), 32'd0);
      chk("rst_err_cycles", 32'(err_cycles), 32'd0);
      do_txn(32'h0100_0000, 1'b0, 4'hF, 32'h0, 1, 0, 32'h0BAD_F00D, 1'b0);
      settle();
      chk("after_rst_data", core_rd, 32'h0BAD_F00D);

      // random traffic, including back-to-back requests and core-side noise
      for (int i = 0; i < 300; i++) begin
         idle($urandom_range(0, 2));
         r = $urandom_range(0, 11);
         slot = (r <= 9) ? r : ((r == 10) ? 255 : N - 1);
         do_txn({8'(slot), 24'($urandom)}, 1'($urandom), 4'($urandom), $urandom,
                $urandom_range(0, TO),
                ($urandom_range(0, 19) == 0) ? $urandom_range(1, 3) : 0,
                $urandom, 1'($urandom));
      end
      idle(2);
      settle();
      chk_en = 1'b0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/sys_bus_ctrl.md
# sys_bus_ctrl

Single-master system-bus controller between the core and the peripheral slots. It decodes the core's memory request by address slot (`addr[31:24]`) and drives a one-hot request to the selected device. It holds the core stalled until that device signals ready, registers the read data, and terminates unmapped or hung accesses with an error response. It replaces the open-coded slot decode and read-data mux in the top level, so multi-cycle peripherals work without per-device stall wiring.

## Interface

Parameters:
- `N_DEV`, default 8: number of decoded slots (0..N_DEV-1); slot index = `core_addr_i[31:24]`.
- `TIMEOUT`, default 15: maximum ACCESS cycles waiting for `dev_ready_i`; range 1..255.
- `ERR_DATA`, default 32'hDEAD_BEEF: read data returned on an error response.

Ports:
- `clk_i`  in  1  system clock. One clock domain; everything is sampled on its rising edge.
- `rst_i`  in  1  reset. Synchronous, active-high.
- `core_req_i`  in  1  core memory request. Held high by the core while stalled.
- `core_we_i`  in  1  write enable (1 = write).
- `core_addr_i`  in  32  byte address.
- `core_be_i`  in  4  byte enables.
- `core_wd_i`  in  32  write data.
- `core_rd_o`  out  32  registered read data. Valid in the DONE cycle.
- `core_stall_o`  out  1  stall to the core.
- `bus_err_o`  out  1  one-cycle error pulse, asserted in the DONE cycle of an errored access.
- `dev_req_o`  out  N_DEV  one-hot device request, registered.
- `dev_we_o`  out  1  latched write enable.
- `dev_be_o`  out  4  latched byte enables.
- `dev_addr_o`  out  32  latched offset `{8'h00, addr[23:0]}`.
- `dev_wd_o`  out  32  latched write data.
- `dev_rd_i`  in  N_DEV*32  device read data; slot k occupies bits `[32k+31:32k]`.
- `dev_ready_i`  in  N_DEV  per-device ready.

## Operation

FSM states are IDLE, ACCESS and DONE.

- **IDLE**
  - With `core_req_i=1` and slot < N_DEV: latch we/be/offset/wd/slot, set `dev_req_o[slot]`, clear the timeout counter, go to ACCESS.
  - With `core_req_i=1` and slot >= N_DEV: set the error flag, load `core_rd_o=ERR_DATA`, go to DONE. No `dev_req_o` is asserted.
  - With `core_req_i=0`: stay in IDLE.
- **ACCESS**
  - `dev_req_o[slot]` stays high.
  - If `dev_ready_i[slot]=1`: capture `dev_rd_i[slot]` into `core_rd_o` (reads only; a write leaves `core_rd_o` unchanged), drop `dev_req_o`, go to DONE.
  - Otherwise increment the counter. If the counter reaches TIMEOUT: drop `dev_req_o`, set the error flag, load `ERR_DATA`, go to DONE.
  - Ready on the TIMEOUT-th cycle counts as success; ready has priority over timeout.
- **DONE**
  - `core_stall_o=0` for exactly this cycle.
  - `bus_err_o` equals the error flag.
  - Always go to IDLE.
- Stall: `core_stall_o = core_req_i & (state != DONE) & ~rst_i`, computed combinationally.
- `dev_ready_i` of non-selected slots is ignored. So is any change to `core_*` inputs during ACCESS, including `core_req_i` falling; the transaction still completes.
- At most one `dev_req_o` bit is ever high.

## Timing

- Reset values:
  - state = IDLE
  - `dev_req_o = 0`
  - `dev_we_o = 0`, `dev_be_o = 0`, `dev_addr_o = 0`, `dev_wd_o = 0`
  - `core_rd_o = 0`
  - `bus_err_o = 0`
  - `core_stall_o = 0`
- Reset asserted in any state: the next cycle is IDLE with all outputs at reset values. An in-flight access is abandoned and no DONE is issued.
- Cycle counts, with n = number of ACCESS cycles:
  - Minimum access: request seen in IDLE (cycle 0), ACCESS with ready (cycle 1), DONE (cycle 2). Stall is high for 2 cycles.
  - Device ready in ACCESS cycle n: DONE at cycle n+1; stall high for n+1 cycles; `dev_req_o` high for n cycles.
  - Unmapped slot: DONE at cycle 1.
  - Timeout: DONE at cycle TIMEOUT+1.
- Back-to-back requests: a new request is accepted in the IDLE cycle after DONE, so the minimum issue interval is 3 cycles.
- Width rules: the timeout counter is 8 bits. Slot compare is unsigned on `addr[31:24]`.

## Test plan

- Read `0x0000_0004`, slot 0 ready immediately, `dev_rd_i[31:0]=0x1234_5678` -> `dev_req_o=0x01` for 1 cycle, `dev_addr_o=0x0000_0004`, DONE at cycle 2, `core_rd_o=0x1234_5678`, stall low for exactly 1 cycle, `bus_err_o=0`.
- Write `0x0300_0010`, wd `0x0000_00A5`, be `4'b0001`, slot 3 ready immediately -> `dev_req_o=0x08`, `dev_we_o=1`, `dev_addr_o=0x0000_0010`, `dev_wd_o=0xA5`, `core_rd_o` unchanged.
- Read slot 7 with ready on the 4th ACCESS cycle, `dev_rd_i` slot 7 = `0xCAFE_0007` -> `dev_req_o=0x80` for 4 cycles, stall high for 5 cycles, `core_rd_o=0xCAFE_0007`. A ready pulse from slot 2 during the wait has no effect.
- Access `0x0900_0000` with N_DEV=8 -> no `dev_req_o`, DONE at cycle 1, `core_rd_o=0xDEAD_BEEF`, `bus_err_o` high for 1 cycle.
- Slot 3 never ready, TIMEOUT=15 -> `dev_req_o` high for 15 cycles, DONE with `0xDEAD_BEEF` and `bus_err_o`. Repeat with ready on ACCESS cycle 15 -> success with no error.
- `rst_i` asserted on the 2nd ACCESS cycle of a slot 0 read -> next cycle `dev_req_o=0`, `core_rd_o=0`, `core_stall_o=0`, no `bus_err_o`. A new request after reset completes normally.
